// File: rtl/exec_wb.sv
// exec_wb: multi-cycle execute/write-back stage (ALU ops, serial shifts, optional shift-add MUL).
// Define EXEC_WB_MUL_EN to build the multiplier for opcode 111; otherwise 111 raises err.
module exec_wb (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [2:0] dst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       we,
    output logic [2:0] waddr,
    output logic [7:0] wdata,
    output logic       flag_z,
    output logic       flag_c,
    output logic       busy,
    output logic       err
);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                           OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;
`ifdef EXEC_WB_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t state_q, state_d;

    logic [2:0] op_q, op_d, dst_q, dst_d, cnt_q, cnt_d, waddr_q, waddr_d;
    logic [7:0] sh_q, sh_d, wdata_q, wdata_d;
    logic       fz_q, fz_d, fc_q, fc_d;
    logic       accept, single;
    logic [8:0] sum;
    logic [7:0] alu_res, step_res;
    logic       alu_c, step_c;
`ifdef EXEC_WB_MUL_EN
    logic [15:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
`endif

    assign accept = in_valid & in_ready;
    assign single = (op <= OP_XOR) || (op == OP_MUL && !MUL_EN) ||
                    ((op == OP_SHL || op == OP_SHR) && b[2:0] == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
`ifdef EXEC_WB_MUL_EN
            acc_q   <= '0;
            mcand_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
`ifdef EXEC_WB_MUL_EN
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = single ? WB : EXEC;
            EXEC:    if (cnt_q == 3'd0) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = a;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: begin alu_res = sum[7:0]; alu_c = sum[8]; end
            OP_SUB: begin alu_res = a - b;    alu_c = (a < b); end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            default: ;
        endcase
    end

    // One EXEC step; MUL reuses the right shift to walk its multiplier bits.
    always_comb begin
        step_res = (op_q == OP_SHL) ? {sh_q[6:0], 1'b0} : {1'b0, sh_q[7:1]};
        step_c   = (op_q == OP_SHL) ? sh_q[7] : sh_q[0];
`ifdef EXEC_WB_MUL_EN
        acc_sum  = acc_q + (sh_q[0] ? mcand_q : 16'h0000);
`endif
    end

    always_comb begin
        op_d    = op_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        fz_d    = fz_q;
        fc_d    = fc_q;
`ifdef EXEC_WB_MUL_EN
        acc_d   = acc_q;
        mcand_d = mcand_q;
`endif
        if (state_q == IDLE && accept) begin
            op_d  = op;
            dst_d = dst;
            sh_d  = (op == OP_MUL) ? b : a;
            cnt_d = (op == OP_MUL) ? 3'd7 : b[2:0] - 3'd1;
`ifdef EXEC_WB_MUL_EN
            acc_d   = '0;
            mcand_d = {8'h00, a};
`endif
            if (single && op != OP_MUL) begin
                waddr_d = dst;
                wdata_d = alu_res;
                fz_d    = (alu_res == 8'h00);
                fc_d    = alu_c;
            end
        end else if (state_q == EXEC) begin
            cnt_d = cnt_q - 3'd1;
            sh_d  = step_res;
`ifdef EXEC_WB_MUL_EN
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
`endif
            if (cnt_q == 3'd0) begin
                waddr_d = dst_q;
`ifdef EXEC_WB_MUL_EN
                if (op_q == OP_MUL) begin
                    wdata_d = acc_sum[7:0];
                    fz_d    = (acc_sum[7:0] == 8'h00);
                    fc_d    = |acc_sum[15:8];
                end else
`endif
                begin
                    wdata_d = step_res;
                    fz_d    = (step_res == 8'h00);
                    fc_d    = step_c;
                end
            end
        end
    end

    always_comb begin
        in_ready = (state_q == IDLE) & ~rst;
        busy     = (state_q != IDLE);
        we       = (state_q == WB) && (MUL_EN || op_q != OP_MUL);
        err      = (state_q == WB) && !MUL_EN && op_q == OP_MUL;
        waddr    = waddr_q;
        wdata    = wdata_q;
        flag_z   = fz_q;
        flag_c   = fc_q;
    end
endmodule
